// File: rtl/btb_predictor_pkg.sv
// btb_predictor_pkg: shared FSM encoding and saturating counter helper for the BTB.
package btb_predictor_pkg;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam int CNT_MAX_W = 4;

    function automatic logic [CNT_MAX_W-1:0] cnt_next(input logic [CNT_MAX_W-1:0] c,
                                                      input logic up,
                                                      input logic [CNT_MAX_W-1:0] max);
        return up ? (c == max ? c : c + 4'd1) : (c == '0 ? c : c - 4'd1);
    endfunction

endpackage

// File: rtl/btb_predictor_ram.sv
// btb_predictor_ram: 2-read/1-write synchronous read-first entry storage.
module btb_predictor_ram #(
    parameter int AW = 10,
    parameter int DW = 43
) (
    input  logic          clk,
    input  logic [AW-1:0] ra0,
    output logic [DW-1:0] rd0,
    input  logic [AW-1:0] ra1,
    output logic [DW-1:0] rd1,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        rd0 <= mem[ra0];
        rd1 <= mem[ra1];
        if (we) mem[wa] <= wd;
    end
endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: tagged BTB with saturating direction counters, 2-cycle update RMW and clear sweep.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int IDX_W    = 10,
    parameter int TAG_W    = 8,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] lu_pc,
    output logic [32:0] pred,
    output logic        pred_hit,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_branch,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic        ready
);
    // An untagged table still stores one constant-zero tag bit so the layout stays uniform.
    localparam int TW = TAG_W > 0 ? TAG_W : 1;
    localparam int EW = 1 + TW + 32 + CNT_W;
    localparam int TL = 32 + CNT_W;
    localparam logic [3:0] CNT_MAX = 4'((1 << CNT_W) - 1);

    function automatic logic [TW-1:0] tag_of(input logic [31:0] pc);
        return TAG_W == 0 ? '0 : pc[2+IDX_W +: TW];
    endfunction

    state_t state;
    logic [IDX_W-1:0] clr_idx, u_idx, wa;
    logic [TW-1:0] u_tag;
    logic [31:0] lu_q, u_tgt;
    logic live, run_q, u_v, u_branch, u_taken, fwd_q;
    logic u_hit, u_we, we, lu_hit, lu_taken;
    logic [EW-1:0] rd0, rd1, cur, nxt, wd, fwd_d;
    logic [CNT_W-1:0] cnt_n;
    logic unused_ok;

    assign unused_ok = ^{lu_pc, upd_pc};

    btb_predictor_ram #(.AW(IDX_W), .DW(EW)) u_ram (
        .clk (clk),
        .ra0 (lu_pc[2 +: IDX_W]),
        .rd0 (rd0),
        .ra1 (upd_pc[2 +: IDX_W]),
        .rd1 (rd1),
        .we  (we),
        .wa  (wa),
        .wd  (wd)
    );

    always_comb begin
        cur      = fwd_q ? fwd_d : rd1;
        u_hit    = cur[EW-1] && cur[TL +: TW] == u_tag;
        cnt_n    = CNT_W'(cnt_next(4'(cur[CNT_W-1:0]), u_taken, CNT_MAX));
        nxt      = !u_branch ? {1'b0, cur[EW-2:0]} :
                   u_hit     ? {1'b1, u_tag, u_taken ? u_tgt : cur[CNT_W +: 32], cnt_n} :
                               {1'b1, u_tag, u_tgt, CNT_W'(CNT_INIT)};
        u_we     = u_v && !rst && !flush && (u_hit || (u_branch && u_taken));
        we       = state == ST_CLEAR || u_we;
        wa       = state == ST_CLEAR ? clr_idx : u_idx;
        wd       = state == ST_CLEAR ? '0 : nxt;
        lu_hit   = run_q && rd0[EW-1] && rd0[TL +: TW] == tag_of(lu_q);
        lu_taken = lu_hit && rd0[CNT_W-1];
        pred     = live ? {lu_taken, lu_taken ? rd0[CNT_W +: 32] : lu_q + 32'd4} : '0;
        pred_hit = lu_hit;
        ready    = state == ST_RUN;
    end

    always_ff @(posedge clk) begin
        live     <= !rst;
        run_q    <= !rst && !flush && state == ST_RUN;
        lu_q     <= lu_pc;
        u_idx    <= upd_pc[2 +: IDX_W];
        u_tag    <= tag_of(upd_pc);
        u_tgt    <= upd_target;
        u_branch <= upd_branch;
        u_taken  <= upd_taken;
        fwd_d    <= nxt;
        if (rst || flush) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            u_v     <= 1'b0;
            fwd_q   <= 1'b0;
        end else begin
            if (state == ST_CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_idx == '1) state <= ST_RUN;
            end
            u_v   <= upd_en && state == ST_RUN;
            fwd_q <= u_we && u_idx == upd_pc[2 +: IDX_W];
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor: directed checks of sweep timing, allocation, counters, tags, flush and aliasing.
module tb_btb_predictor;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] lu_pc = '0, upd_pc = '0, upd_target = '0;
    logic upd_en = 1'b0, upd_branch = 1'b0, upd_taken = 1'b0;
    logic [32:0] pred;
    logic pred_hit, ready;

    logic [31:0] a_lu_pc = '0, a_upd_pc = '0, a_upd_target = '0;
    logic a_flush = 1'b0, a_upd_en = 1'b0, a_upd_branch = 1'b0, a_upd_taken = 1'b0;
    logic [32:0] a_pred;
    logic a_pred_hit, a_ready;

    int total = 0, bad = 0;

    btb_predictor dut (
        .clk(clk), .rst(rst), .flush(flush), .lu_pc(lu_pc), .pred(pred), .pred_hit(pred_hit),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_branch(upd_branch), .upd_taken(upd_taken),
        .upd_target(upd_target), .ready(ready)
    );

    btb_predictor #(.IDX_W(4), .TAG_W(0)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush), .lu_pc(a_lu_pc), .pred(a_pred), .pred_hit(a_pred_hit),
        .upd_en(a_upd_en), .upd_pc(a_upd_pc), .upd_branch(a_upd_branch), .upd_taken(a_upd_taken),
        .upd_target(a_upd_target), .ready(a_ready)
    );

    typedef struct {
        logic        en, br, tk;
        logic [31:0] pc, tgt, lu;
        logic        chk;
        logic [33:0] exp;
    } vec_t;

    function automatic logic [33:0] e(input logic hit, input logic tk, input logic [31:0] tgt);
        return {hit, tk, tgt};
    endfunction

    function automatic vec_t u(input logic br, input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
        return '{1'b1, br, tk, pc, tgt, pc, 1'b0, 34'd0};
    endfunction

    function automatic vec_t l(input logic [31:0] lu, input logic [33:0] exp);
        return '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, lu, 1'b1, exp};
    endfunction

    function automatic vec_t n(input logic [31:0] lu);
        return '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0, lu, 1'b0, 34'd0};
    endfunction

    task automatic cyc(input logic [31:0] lu, input logic en, input logic [31:0] pc,
                       input logic br, input logic tk, input logic [31:0] tgt);
        lu_pc = lu; upd_en = en; upd_pc = pc; upd_branch = br; upd_taken = tk; upd_target = tgt;
        @(negedge clk);
        upd_en = 1'b0;
    endtask

    task automatic a_cyc(input logic [31:0] lu, input logic en, input logic [31:0] pc,
                         input logic br, input logic tk, input logic [31:0] tgt);
        a_lu_pc = lu; a_upd_en = en; a_upd_pc = pc; a_upd_branch = br; a_upd_taken = tk; a_upd_target = tgt;
        @(negedge clk);
        a_upd_en = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; lu_pc = 32'h40;
        repeat (3) @(negedge clk);
        total++;
        if ({pred_hit, pred, ready} !== 35'd0) begin
            bad++; $display("FAIL reset_state got=%h exp=0", {pred_hit, pred, ready});
        end
        rst = 1'b0;
        for (int i = 1; i <= 1024; i++) begin
            @(negedge clk);
            total++;
            if (ready !== 1'(i == 1024) || {pred_hit, pred} !== e(1'b0, 1'b0, 32'h44)) begin
                bad++; $display("FAIL sweep[%0d] ready=%b pred=%h hit=%b", i, ready, pred, pred_hit);
            end
        end
    endtask

    task automatic test_alloc;
        vec_t v[$];
        v.push_back('{1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 32'h100, 1'b1, e(1'b0, 1'b0, 32'h104)});
        v.push_back(l(32'h100, e(1'b0, 1'b0, 32'h104)));
        v.push_back(l(32'h100, e(1'b1, 1'b1, 32'h200)));
        foreach (v[i]) begin
            cyc(v[i].lu, v[i].en, v[i].pc, v[i].br, v[i].tk, v[i].tgt);
            if (v[i].chk) begin
                total++;
                if ({pred_hit, pred} !== v[i].exp) begin
                    bad++; $display("FAIL alloc[%0d] got=%h exp=%h", i, {pred_hit, pred}, v[i].exp);
                end
            end
        end
    endtask

    task automatic test_counter;
        vec_t v[$];
        v.push_back(u(1, 0, 32'h100, 32'h0)); v.push_back(u(1, 0, 32'h100, 32'h0));
        v.push_back(n(32'h100)); v.push_back(l(32'h100, e(1'b1, 1'b0, 32'h104)));
        v.push_back(u(1, 0, 32'h100, 32'h0));
        v.push_back(n(32'h100)); v.push_back(l(32'h100, e(1'b1, 1'b0, 32'h104)));
        v.push_back(u(1, 1, 32'h100, 32'h200)); v.push_back(u(1, 1, 32'h100, 32'h200));
        v.push_back(u(1, 1, 32'h100, 32'h240));
        v.push_back(n(32'h100)); v.push_back(l(32'h100, e(1'b1, 1'b1, 32'h240)));
        v.push_back(u(1, 1, 32'h100, 32'h240)); v.push_back(u(1, 0, 32'h100, 32'h999));
        v.push_back(n(32'h100)); v.push_back(l(32'h100, e(1'b1, 1'b1, 32'h240)));
        v.push_back(u(1, 0, 32'h100, 32'h0)); v.push_back(u(1, 0, 32'h100, 32'h0));
        v.push_back(n(32'h100)); v.push_back(l(32'h100, e(1'b1, 1'b0, 32'h104)));
        foreach (v[i]) begin
            cyc(v[i].lu, v[i].en, v[i].pc, v[i].br, v[i].tk, v[i].tgt);
            if (v[i].chk) begin
                total++;
                if ({pred_hit, pred} !== v[i].exp) begin
                    bad++; $display("FAIL counter[%0d] got=%h exp=%h", i, {pred_hit, pred}, v[i].exp);
                end
            end
        end
    endtask

    task automatic test_tag_replace;
        vec_t v[$];
        v.push_back(u(1, 1, 32'h1100, 32'h300)); v.push_back(n(32'h0));
        v.push_back(l(32'h100, e(1'b0, 1'b0, 32'h104)));
        v.push_back(l(32'h1100, e(1'b1, 1'b1, 32'h300)));
        v.push_back(u(1, 0, 32'h2100, 32'h0)); v.push_back(u(0, 0, 32'h3100, 32'h0));
        v.push_back(n(32'h0)); v.push_back(l(32'h1100, e(1'b1, 1'b1, 32'h300)));
        v.push_back(u(0, 0, 32'h1100, 32'h0)); v.push_back(n(32'h0));
        v.push_back(l(32'h1100, e(1'b0, 1'b0, 32'h1104)));
        foreach (v[i]) begin
            cyc(v[i].lu, v[i].en, v[i].pc, v[i].br, v[i].tk, v[i].tgt);
            if (v[i].chk) begin
                total++;
                if ({pred_hit, pred} !== v[i].exp) begin
                    bad++; $display("FAIL tag_replace[%0d] got=%h exp=%h", i, {pred_hit, pred}, v[i].exp);
                end
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] pcs [5] = '{32'h100, 32'h700, 32'h500, 32'h800, 32'hFFFF_FFFC};
        cyc(32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h200);
        cyc(32'h100, 1'b1, 32'h700, 1'b1, 1'b1, 32'h710);
        cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        total++;
        if ({pred_hit, pred} !== e(1'b1, 1'b1, 32'h200)) begin
            bad++; $display("FAIL flush_pre got=%h exp=%h", {pred_hit, pred}, e(1'b1, 1'b1, 32'h200));
        end
        flush = 1'b1;
        cyc(32'h100, 1'b1, 32'h500, 1'b1, 1'b1, 32'h600);
        flush = 1'b0;
        total++;
        if (ready !== 1'b0 || {pred_hit, pred} !== e(1'b0, 1'b0, 32'h104)) begin
            bad++; $display("FAIL flush_cycle ready=%b pred=%h hit=%b", ready, pred, pred_hit);
        end
        for (int i = 1; i <= 1024; i++) begin
            cyc(32'h100, 1'(i == 1020), 32'h800, 1'b1, 1'b1, 32'h880);
            total++;
            if (ready !== 1'(i == 1024) || {pred_hit, pred} !== e(1'b0, 1'b0, 32'h104)) begin
                bad++; $display("FAIL flush_sweep[%0d] ready=%b pred=%h hit=%b", i, ready, pred, pred_hit);
            end
        end
        cyc(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        foreach (pcs[i]) begin
            cyc(pcs[i], 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            total++;
            if ({pred_hit, pred} !== e(1'b0, 1'b0, pcs[i] + 32'd4)) begin
                bad++; $display("FAIL flush_miss[%0d] got=%h exp=%h", i, {pred_hit, pred}, e(1'b0, 1'b0, pcs[i] + 32'd4));
            end
        end
    endtask

    task automatic test_untagged;
        vec_t v[$];
        v.push_back('{1'b1, 1'b1, 1'b1, 32'h0, 32'h80, 32'h0, 1'b1, e(1'b0, 1'b0, 32'h4)});
        v.push_back(n(32'h0));
        v.push_back(l(32'h40, e(1'b1, 1'b1, 32'h80)));
        v.push_back(l(32'h4, e(1'b0, 1'b0, 32'h8)));
        v.push_back(u(1, 0, 32'h40, 32'h0)); v.push_back(n(32'h0));
        v.push_back(l(32'h0, e(1'b1, 1'b0, 32'h4)));
        total++;
        if (a_ready !== 1'b1) begin
            bad++; $display("FAIL untagged_ready got=%b exp=1", a_ready);
        end
        foreach (v[i]) begin
            a_cyc(v[i].lu, v[i].en, v[i].pc, v[i].br, v[i].tk, v[i].tgt);
            if (v[i].chk) begin
                total++;
                if ({a_pred_hit, a_pred} !== v[i].exp) begin
                    bad++; $display("FAIL untagged[%0d] got=%h exp=%h", i, {a_pred_hit, a_pred}, v[i].exp);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_alloc;
        test_counter;
        test_tag_replace;
        test_flush;
        test_untagged;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
